flex_mode_counter: RTL and testbench
====================================

Name: flex_mode_counter

Overview:
- Parametrised, mode-selectable counter that replaces ad-hoc fixed-width counters in fpga_top designs.
- Counts up or down between 0 and a runtime terminal value, with three modes: wrap, saturate and one-shot.
- Supports synchronous clear and synchronous load, and produces a registered terminal flag and a sticky done flag.
- Intended as the shared timing/counting primitive for the continuous-counting checks in the fpga_top benches.

Parameters:
- NUM_BITS, 4, counter width W (2..32).
- PRESCALE_BITS, 4, prescaler width; used only when FMC_PRESCALE_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear; highest priority.
- load  input  1  synchronous load of load_val.
- load_val  input  NUM_BITS  value captured on load.
- count_enable  input  1  advance the counter when high.
- dir  input  1  1 = count up, 0 = count down.
- mode  input  2  counting mode, see mode_t.
- rollover_val  input  NUM_BITS  terminal value R.
- prescale  input  PRESCALE_BITS  divide ratio minus 1; port exists only with FMC_PRESCALE_EN.
- count_out  output  NUM_BITS  current count, registered.
- rollover_flag  output  1  registered; high while the count sits at terminal.
- done  output  1  sticky one-shot completion flag.

Behaviour:
- Reset:
  - One clock (clk); reset is asynchronous and active-low (nrst).
  - On reset: count_out=0, rollover_flag=0, done=0, prescaler=0.
- Priority each rising edge: clear > load > count.
  - clear: count_out=0, rollover_flag=0, done=0.
  - load: count_out=load_val, done=0; rollover_flag is recomputed from load_val.
- Terminal condition T:
  - Up: next_count >= R. The >= compare covers load_val > R.
  - Down: next_count == 0.
- rollover_flag is the registered value of T for the value being written into count_out, so it is high in the same cycle count_out shows the terminal value.
- Counting step (count_enable=1, no clear or load):
  - WRAP (2'b00), up: at count>=R the next count is 0, otherwise count+1.
  - WRAP, down: at count==0 the next count is R, otherwise count-1.
  - SAT (2'b01): at terminal the count holds. rollover_flag stays high while it holds.
  - ONESHOT (2'b10): advances until terminal. On the edge that reaches terminal, done is set to 1 and the counter freezes.
    - It stays frozen until clear or load, ignoring count_enable and dir.
- mode 2'b11 is reserved and behaves as WRAP.
- R=0:
  - Up WRAP holds 0 with rollover_flag=1.
  - Down WRAP holds 0 with rollover_flag=1.
  - ONESHOT sets done on the first enabled edge.
- count_enable=0: the count and done hold. rollover_flag reflects the held count.
- Changes to dir, mode or R mid-count take effect on the next enabled edge. There is no glitch on any output, and no extra latency.
- Arithmetic: a W-bit unsigned increment/decrement can never overflow past 2^W-1, because the terminal compare precedes it.
- Reset mid-count returns all outputs to their reset values immediately (asynchronously).
- Latency: one cycle from an input to count_out, rollover_flag and done.

Optional Feature:
- Macro: FMC_PRESCALE_EN.
- Defined:
  - Adds the prescale port and a PRESCALE_BITS internal divider.
  - The counter advances only on enabled cycles where the divider equals prescale; the divider then resets to 0.
  - The divider increments on every other enabled cycle.
  - clear and load also zero the divider.
  - prescale=0 is equivalent to no prescaling.
- Undefined: no port and no divider; every enabled cycle advances the counter.

Decomposition:
- Package fmc_pkg:
  - typedef enum logic [1:0] mode_t {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD}.
  - Localparams DIR_UP=1'b1 and DIR_DOWN=1'b0.
- One natural sub-module, fmc_tick_div: the prescaler. It takes clk, nrst, clear, enable and ratio, and outputs a single-cycle tick. It is instantiated only under FMC_PRESCALE_EN.

Test Plan:
- Reset: assert nrst=0 mid-count at count_out=5 -> count_out=0, rollover_flag=0 and done=0 immediately, without waiting for a clock edge.
- WRAP up: NUM_BITS=4, R=9, enable held for 12 cycles -> count_out runs 1..9,0,1,2; rollover_flag is high only in the cycle count_out=9.
- WRAP down: dir=0, R=5, load 3 then enable for 5 cycles -> 2,1,0,5,4; rollover_flag is high at 0.
- SAT and ONESHOT:
  - SAT up, R=15: count holds at 15 with rollover_flag=1 for 3 extra enabled cycles.
  - ONESHOT, R=3: done=1 at count 3 and stays frozen for 5 more cycles. A subsequent clear gives 0 with done=0.
- Priority: clear=1, load=1, load_val=7 and enable all in the same cycle -> count_out=0. Then load=1 with enable=1 -> count_out=7, not 8. Load 12 with R=9 (up, WRAP) -> rollover_flag=1, and the next enabled edge gives 0.
- FMC_PRESCALE_EN: prescale=2, R=9, enable for 9 cycles -> count_out goes 0->1->2->3, advancing on enabled cycles 3, 6 and 9 only.

Source files
------------

// File: rtl/fmc_pkg.sv
// -----------------------------------------------------------------------------
// fmc_pkg
//
// Shared types and constants for flex_mode_counter and its prescaler.
//
//   mode_t    : counting mode selected on the counter's mode input
//               MODE_WRAP    (2'b00) wrap at the terminal value
//               MODE_SAT     (2'b01) hold at the terminal value
//               MODE_ONESHOT (2'b10) stop at the terminal value, set done
//               MODE_RSVD    (2'b11) reserved, decoded as MODE_WRAP
//   DIR_UP    : dir input value for counting up
//   DIR_DOWN  : dir input value for counting down
// -----------------------------------------------------------------------------
package fmc_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : fmc_pkg

// File: rtl/fmc_tick_div.sv
// -----------------------------------------------------------------------------
// fmc_tick_div
//
// Enable-qualified prescaler for flex_mode_counter. Counts enabled cycles and
// produces a single-cycle tick on the enabled cycle where the divider has
// reached the programmed ratio; the divider returns to 0 on that cycle. A
// ratio of 0 therefore ticks on every enabled cycle.
//
// This module only exists when FMC_PRESCALE_EN is defined; without the macro
// the counter has no divider and this file contributes nothing.
//
// Ports:
//   clk    : system clock, rising edge
//   nrst   : asynchronous active-low reset, divider -> 0
//   clear  : synchronous divider clear (counter clear or load)
//   enable : count_enable of the parent counter
//   ratio  : divide ratio minus 1
//   tick   : high for the enabled cycle on which the counter may advance
// -----------------------------------------------------------------------------
`ifdef FMC_PRESCALE_EN
module fmc_tick_div #(
    parameter int RATIO_BITS = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [RATIO_BITS-1:0] ratio,
    output logic                  tick
);

    localparam logic [RATIO_BITS-1:0] DIV_ONE = RATIO_BITS'(1);

    logic [RATIO_BITS-1:0] div_q;
    logic                  at_ratio;

    // '>=' rather than '==' so that lowering ratio below the current divider
    // value mid-run produces a tick next enabled cycle instead of a long wrap
    // through the whole divider range.
    assign at_ratio = (div_q >= ratio);
    assign tick     = enable && at_ratio;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_q <= '0;
        end else if (clear) begin
            div_q <= '0;
        end else if (enable) begin
            if (at_ratio) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_ONE;
            end
        end
    end

endmodule : fmc_tick_div
`endif

// File: rtl/flex_mode_counter.sv
// -----------------------------------------------------------------------------
// flex_mode_counter
//
// Parametrised up/down counter with a runtime terminal value and three modes
// (wrap, saturate, one-shot). Shared timing/counting primitive for the
// fpga_top designs.
//
// Optional feature: define FMC_PRESCALE_EN to add the prescale port and an
// internal PRESCALE_BITS divider (fmc_tick_div). Without the macro every
// enabled cycle advances the counter.
//
// Parameters:
//   NUM_BITS      : counter width, 2..32
//   PRESCALE_BITS : prescaler width (only used with FMC_PRESCALE_EN)
//
// Ports:
//   clk           : system clock, rising edge
//   nrst          : asynchronous active-low reset
//   clear         : synchronous clear, highest priority
//   load          : synchronous load of load_val, below clear
//   load_val      : value captured on load
//   count_enable  : advance the counter when high
//   dir           : 1 = up (DIR_UP), 0 = down (DIR_DOWN)
//   mode          : counting mode, see fmc_pkg::mode_t
//   rollover_val  : terminal value R
//   prescale      : divide ratio minus 1 (FMC_PRESCALE_EN only)
//   count_out     : current count, registered
//   rollover_flag : registered; high while count_out sits at terminal
//   done          : sticky one-shot completion flag
//
// Control protocol: there is no handshake. Each rising edge applies exactly
// one of clear, load or an enabled count step (in that priority), and every
// output reflects that edge's result one cycle after the inputs were applied.
// -----------------------------------------------------------------------------
module flex_mode_counter
    import fmc_pkg::*;
#(
    parameter int NUM_BITS      = 4,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     clear,
    input  logic                     load,
    input  logic [NUM_BITS-1:0]      load_val,
    input  logic                     count_enable,
    input  logic                     dir,
    input  logic [1:0]               mode,
    input  logic [NUM_BITS-1:0]      rollover_val,
`ifdef FMC_PRESCALE_EN
    input  logic [PRESCALE_BITS-1:0] prescale,
`endif
    output logic [NUM_BITS-1:0]      count_out,
    output logic                     rollover_flag,
    output logic                     done
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------------
    if (NUM_BITS < 2 || NUM_BITS > 32) begin : g_bad_num_bits
        $error("flex_mode_counter: NUM_BITS must be in 2..32");
    end
    if (PRESCALE_BITS < 1) begin : g_bad_prescale_bits
        $error("flex_mode_counter: PRESCALE_BITS must be at least 1");
    end

    localparam logic [NUM_BITS-1:0] CNT_ONE = NUM_BITS'(1);

    // Terminal condition: up counts terminate at or beyond R (a load above R
    // counts as terminal), down counts terminate at zero.
    function automatic logic is_term(input logic [NUM_BITS-1:0] val,
                                     input logic                up,
                                     input logic [NUM_BITS-1:0] r);
        return up ? (val >= r) : (val == '0);
    endfunction

    // -------------------------------------------------------------------------
    // Advance qualifier (prescaler tick or every enabled cycle)
    // -------------------------------------------------------------------------
    logic tick;

`ifdef FMC_PRESCALE_EN
    fmc_tick_div #(
        .RATIO_BITS (PRESCALE_BITS)
    ) u_tick_div (
        .clk    (clk),
        .nrst   (nrst),
        .clear  (clear | load),
        .enable (count_enable),
        .ratio  (prescale),
        .tick   (tick)
    );
`else
    assign tick = count_enable;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    mode_t               mode_sel;
    logic                dir_up;
    logic                cur_term;
    logic                advance;
    logic [NUM_BITS-1:0] step_val;
    logic [NUM_BITS-1:0] next_count;
    logic                next_flag;
    logic                next_done;

    assign mode_sel = mode_t'(mode);
    assign dir_up   = (dir == DIR_UP);

    // Once a one-shot completes the counter is frozen until clear or load,
    // regardless of count_enable, dir or a later mode change.
    assign advance  = count_enable && tick && !done;

    always_comb begin
        step_val = count_out;
        cur_term = is_term(count_out, dir_up, rollover_val);

        case (mode_sel)
            MODE_SAT, MODE_ONESHOT: begin
                // Hold at terminal; the one-shot freeze is applied via done.
                if (cur_term) begin
                    step_val = count_out;
                end else if (dir_up) begin
                    step_val = count_out + CNT_ONE;
                end else begin
                    step_val = count_out - CNT_ONE;
                end
            end
            default: begin
                // MODE_WRAP and the reserved encoding. The terminal compare
                // is taken before the increment/decrement, so the W-bit step
                // never rolls over on its own.
                if (dir_up) begin
                    step_val = cur_term ? '0 : (count_out + CNT_ONE);
                end else begin
                    step_val = cur_term ? rollover_val : (count_out - CNT_ONE);
                end
            end
        endcase

        next_count = advance ? step_val : count_out;

        // rollover_flag is registered alongside count_out so it is high in the
        // same cycle count_out shows a terminal value, including while held.
        next_flag  = is_term(next_count, dir_up, rollover_val);

        next_done  = done ||
                     (advance && (mode_sel == MODE_ONESHOT) &&
                      is_term(step_val, dir_up, rollover_val));
    end

    // -------------------------------------------------------------------------
    // State registers: clear > load > count
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            done          <= 1'b0;
        end else if (clear) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            done          <= 1'b0;
        end else if (load) begin
            count_out     <= load_val;
            rollover_flag <= is_term(load_val, dir_up, rollover_val);
            done          <= 1'b0;
        end else begin
            count_out     <= next_count;
            rollover_flag <= next_flag;
            done          <= next_done;
        end
    end

endmodule : flex_mode_counter

// File: tb/tb_flex_mode_counter.sv
// -----------------------------------------------------------------------------
// tb_flex_mode_counter
//
// Directed bench for flex_mode_counter (NUM_BITS=4). The driver applies one
// input vector per clock at the falling edge and pushes the hand-computed
// {count_out, rollover_flag, done} for the following rising edge into exp_q;
// the monitor samples 1 time unit after every rising edge and pops/compares
// whenever an expectation is pending. The asynchronous reset is checked
// directly, between clock edges. Define FMC_PRESCALE_EN to add the
// prescaler sequence.
// -----------------------------------------------------------------------------
module tb_flex_mode_counter;
    import fmc_pkg::*;

    localparam int W  = 4;
    localparam int PB = 4;
    localparam int EW = W + 2;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic tb_clk = 1'b0;
    logic nrst;

    always #5 tb_clk = ~tb_clk;

    // -------------------------------------------------------------------------
    // DUT
    // -------------------------------------------------------------------------
    logic          clear;
    logic          load;
    logic [W-1:0]  load_val;
    logic          count_enable;
    logic          dir;
    logic [1:0]    mode;
    logic [W-1:0]  rollover_val;
`ifdef FMC_PRESCALE_EN
    logic [PB-1:0] prescale;
`endif
    logic [W-1:0]  count_out;
    logic          rollover_flag;
    logic          done;

    flex_mode_counter #(
        .NUM_BITS      (W),
        .PRESCALE_BITS (PB)
    ) dut (
        .clk           (tb_clk),
        .nrst          (nrst),
        .clear         (clear),
        .load          (load),
        .load_val      (load_val),
        .count_enable  (count_enable),
        .dir           (dir),
        .mode          (mode),
        .rollover_val  (rollover_val),
`ifdef FMC_PRESCALE_EN
        .prescale      (prescale),
`endif
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .done          (done)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic drive(input string        tag,
                         input logic         c,
                         input logic         l,
                         input logic [W-1:0] lv,
                         input logic         en,
                         input logic         d,
                         input logic [1:0]   m,
                         input logic [W-1:0] r,
                         input logic [W-1:0] e_cnt,
                         input logic         e_flag,
                         input logic         e_done);
        @(negedge tb_clk);
        clear        = c;
        load         = l;
        load_val     = lv;
        count_enable = en;
        dir          = d;
        mode         = m;
        rollover_val = r;
        exp_q.push_back({e_cnt, e_flag, e_done});
        name_q.push_back(tag);
    endtask

    // Wait for the monitor to consume all pending expectations.
    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge tb_clk);
            #2;
            budget++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d expectations still pending, required 0",
                     exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic check_now(input string tag, input logic [EW-1:0] act,
                             input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d flag=%0b done=%0b, required cnt=%0d flag=%0b done=%0b",
                     tag, act[EW-1:2], act[1], act[0], exp[EW-1:2], exp[1], exp[0]);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    initial begin
        logic [EW-1:0] exp;
        logic [EW-1:0] act;
        string         tag;
        forever begin
            @(posedge tb_clk);
            #1;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                tag = name_q.pop_front();
                act = {count_out, rollover_flag, done};
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL %s: got cnt=%0d flag=%0b done=%0b, required cnt=%0d flag=%0b done=%0b",
                             tag, act[EW-1:2], act[1], act[0], exp[EW-1:2], exp[1], exp[0]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [W-1:0] ec;

        nrst         = 1'b0;
        clear        = 1'b0;
        load         = 1'b0;
        load_val     = '0;
        count_enable = 1'b0;
        dir          = DIR_UP;
        mode         = MODE_WRAP;
        rollover_val = 4'd9;
`ifdef FMC_PRESCALE_EN
        prescale     = '0;
`endif

        // Reset state
        repeat (2) @(posedge tb_clk);
        #1;
        check_now("reset_state", {count_out, rollover_flag, done}, {4'd0, 1'b0, 1'b0});
        @(negedge tb_clk);
        nrst = 1'b1;

        // WRAP up, R=9: 1..9,0,1,2 with the flag only at 9
        for (int i = 1; i <= 12; i++) begin
            ec = (i <= 9) ? W'(i) : W'(i - 10);
            drive("wrap_up", 0, 0, 4'd0, 1, DIR_UP, MODE_WRAP, 4'd9, ec, ec == 4'd9, 0);
        end

        // Priority: clear beats load and enable; load beats enable
        drive("prio_clear", 1, 1, 4'd7, 1, DIR_UP, MODE_WRAP, 4'd9, 4'd0, 0, 0);
        drive("prio_load",  0, 1, 4'd7, 1, DIR_UP, MODE_WRAP, 4'd9, 4'd7, 0, 0);
        drive("load_above", 0, 1, 4'd12, 0, DIR_UP, MODE_WRAP, 4'd9, 4'd12, 1, 0);
        drive("above_wrap", 0, 0, 4'd0, 1, DIR_UP, MODE_WRAP, 4'd9, 4'd0, 0, 0);

        // WRAP down, R=5: load 3 then 2,1,0,5,4
        drive("dn_load", 0, 1, 4'd3, 0, DIR_DOWN, MODE_WRAP, 4'd5, 4'd3, 0, 0);
        drive("wrap_dn", 0, 0, 4'd0, 1, DIR_DOWN, MODE_WRAP, 4'd5, 4'd2, 0, 0);
        drive("wrap_dn", 0, 0, 4'd0, 1, DIR_DOWN, MODE_WRAP, 4'd5, 4'd1, 0, 0);
        drive("wrap_dn", 0, 0, 4'd0, 1, DIR_DOWN, MODE_WRAP, 4'd5, 4'd0, 1, 0);
        drive("wrap_dn", 0, 0, 4'd0, 1, DIR_DOWN, MODE_WRAP, 4'd5, 4'd5, 0, 0);
        drive("wrap_dn", 0, 0, 4'd0, 1, DIR_DOWN, MODE_WRAP, 4'd5, 4'd4, 0, 0);

        // SAT up, R=15: reach 15 then hold for 3 extra enabled cycles
        drive("sat_load", 0, 1, 4'd12, 0, DIR_UP, MODE_SAT, 4'd15, 4'd12, 0, 0);
        drive("sat_up",   0, 0, 4'd0, 1, DIR_UP, MODE_SAT, 4'd15, 4'd13, 0, 0);
        drive("sat_up",   0, 0, 4'd0, 1, DIR_UP, MODE_SAT, 4'd15, 4'd14, 0, 0);
        drive("sat_up",   0, 0, 4'd0, 1, DIR_UP, MODE_SAT, 4'd15, 4'd15, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive("sat_hold", 0, 0, 4'd0, 1, DIR_UP, MODE_SAT, 4'd15, 4'd15, 1, 0);
        end

        // ONESHOT, R=3: done at 3, frozen for 5 more cycles, then clear
        drive("os_clear", 1, 0, 4'd0, 0, DIR_UP, MODE_ONESHOT, 4'd3, 4'd0, 0, 0);
        drive("os_up",    0, 0, 4'd0, 1, DIR_UP, MODE_ONESHOT, 4'd3, 4'd1, 0, 0);
        drive("os_up",    0, 0, 4'd0, 1, DIR_UP, MODE_ONESHOT, 4'd3, 4'd2, 0, 0);
        drive("os_done",  0, 0, 4'd0, 1, DIR_UP, MODE_ONESHOT, 4'd3, 4'd3, 1, 1);
        for (int i = 0; i < 5; i++) begin
            drive("os_frozen", 0, 0, 4'd0, (i % 2) == 0, DIR_UP, MODE_ONESHOT, 4'd3,
                  4'd3, 1, 1);
        end
        drive("os_reclear", 1, 0, 4'd0, 1, DIR_UP, MODE_ONESHOT, 4'd3, 4'd0, 0, 0);

        // R=0 corner cases
        drive("r0_wrap_up", 0, 0, 4'd0, 1, DIR_UP,   MODE_WRAP, 4'd0, 4'd0, 1, 0);
        drive("r0_wrap_dn", 0, 0, 4'd0, 1, DIR_DOWN, MODE_WRAP, 4'd0, 4'd0, 1, 0);
        drive("r0_clear",   1, 0, 4'd0, 0, DIR_UP,   MODE_ONESHOT, 4'd0, 4'd0, 0, 0);
        drive("r0_oneshot", 0, 0, 4'd0, 1, DIR_UP,   MODE_ONESHOT, 4'd0, 4'd0, 1, 1);
        drive("r0_reclear", 1, 0, 4'd0, 0, DIR_UP,   MODE_WRAP, 4'd9, 4'd0, 0, 0);

        // Reserved mode decodes as WRAP: 9 -> 0
        drive("rsvd_load", 0, 1, 4'd9, 0, DIR_UP, MODE_RSVD, 4'd9, 4'd9, 1, 0);
        drive("rsvd_wrap", 0, 0, 4'd0, 1, DIR_UP, MODE_RSVD, 4'd9, 4'd0, 0, 0);

        // count_enable=0 holds count; flag follows the held count
        drive("hold_load", 0, 1, 4'd5, 0, DIR_UP, MODE_WRAP, 4'd9, 4'd5, 0, 0);
        drive("hold",      0, 0, 4'd0, 0, DIR_UP, MODE_WRAP, 4'd9, 4'd5, 0, 0);
        drive("hold_term", 0, 1, 4'd9, 0, DIR_UP, MODE_WRAP, 4'd9, 4'd9, 1, 0);
        drive("hold_term", 0, 0, 4'd0, 0, DIR_UP, MODE_WRAP, 4'd9, 4'd9, 1, 0);

        // Asynchronous reset mid-count at count_out=5
        drive("pre_reset", 0, 1, 4'd4, 0, DIR_UP, MODE_WRAP, 4'd9, 4'd4, 0, 0);
        drive("pre_reset", 0, 0, 4'd0, 1, DIR_UP, MODE_WRAP, 4'd9, 4'd5, 0, 0);
        drain();
        @(negedge tb_clk);
        #2;
        nrst = 1'b0;
        #1;
        check_now("async_reset", {count_out, rollover_flag, done}, {4'd0, 1'b0, 1'b0});
        @(negedge tb_clk);
        count_enable = 1'b0;
        nrst         = 1'b1;

`ifdef FMC_PRESCALE_EN
        // prescale=2, R=9: advance on enabled cycles 3, 6 and 9 only
        drive("ps_clear", 1, 0, 4'd0, 0, DIR_UP, MODE_WRAP, 4'd9, 4'd0, 0, 0);
        prescale = 4'd2;
        for (int i = 1; i <= 9; i++) begin
            drive("prescale", 0, 0, 4'd0, 1, DIR_UP, MODE_WRAP, 4'd9, W'(i / 3), 0, 0);
        end
`endif

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flex_mode_counter
